// File: rtl/serial_add_pkg.sv
// Shared definitions for the byte-serial adder controller.
//   BYTE_W  : width of one datapath step (the adder_n slice width)
//   state_t : controller FSM encoding (IDLE / RUN / FIN)
package serial_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_n.sv
// N-bit ripple adder datapath slice, driven one byte per clock by the
// serial controller.
// Ports:
//   a, b : addends (N bits)
//   cin  : carry in
//   sum  : a + b + cin modulo 2^N
//   cout : carry out of bit N-1
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Byte-serial multi-precision adder controller. Captures two W-bit operands
// and a carry-in on an accepted start, feeds adder_n one byte per clock
// (LSB first) with the carry chained through carry_q, and presents the wide
// sum/cout together with a one-cycle done pulse.
// Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' input that turns
// the operation into A - B (B inverted byte-wise, carry-in forced to 1).
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   start    : request, sampled only in IDLE
//   a_in     : operand A (W bits), captured on accept
//   b_in     : operand B (W bits), captured on accept
//   cin_in   : carry-in for byte 0, captured on accept
//   sub      : (SERIAL_ADD_SUB_EN only) subtract select, captured on accept
//   busy     : high from the cycle after accept through the done cycle
//   done     : one-cycle pulse, sum_out/cout_out valid
//   sum_out  : W-bit result, held until the next accepted start
//   cout_out : carry out of the MSB byte, held like sum_out
import serial_add_pkg::*;

module serial_add_ctrl #(
  parameter  int NBYTES = 4,
  localparam int W      = NBYTES * BYTE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_out,
  output logic         cout_out
);

  localparam int CW = $clog2(NBYTES + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      a_sh, b_sh;
  logic [W-BYTE_W-1:0] acc;       // bytes already produced, newest on top
  logic              carry_q;
  logic              last_step;

  logic [BYTE_W-1:0] add_a, add_b, add_sum;
  logic              add_cout;
  logic [W-1:0]      acc_ext;     // acc with the current byte sum on top

`ifdef SERIAL_ADD_SUB_EN
  logic              sub_q;
  assign add_b = b_sh[BYTE_W-1:0] ^ {BYTE_W{sub_q}};
`else
  assign add_b = b_sh[BYTE_W-1:0];
`endif
  assign add_a     = a_sh[BYTE_W-1:0];
  assign last_step = (cnt == CW'(NBYTES - 1));
  assign acc_ext   = {add_sum, acc};

  adder_n #(.N(BYTE_W)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      FIN:     begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: operand capture, byte stepping and result registers.
  // The result registers load on the edge that completes the last byte, so
  // they already hold the final value during the FIN (done) cycle and change
  // nowhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry_q  <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= a_in;
          b_sh <= b_in;
          cnt  <= '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_q   <= sub;
          carry_q <= sub ? 1'b1 : cin_in;  // two's complement: ~B + 1
`else
          carry_q <= cin_in;
`endif
        end
        RUN: begin
          a_sh    <= a_sh >> BYTE_W;
          b_sh    <= b_sh >> BYTE_W;
          acc     <= acc_ext[W-1:BYTE_W];
          carry_q <= add_cout;
          cnt     <= cnt + CW'(1);
          if (last_step) begin
            sum_out  <= acc_ext;
            cout_out <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // NBYTES=4 instance
  logic        start4, cin4, busy4, done4, cout4;
  logic [31:0] a4, b4, sum4;
`ifdef SERIAL_ADD_SUB_EN
  logic        sub4, sub2;
`endif

  // NBYTES=2 instance
  logic        start2, cin2, busy2, done2, cout2;
  logic [15:0] a2, b2, sum2;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.NBYTES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_in(a4), .b_in(b4), .cin_in(cin4),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .sum_out(sum4), .cout_out(cout4)
  );

  serial_add_ctrl #(.NBYTES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a_in(a2), .b_in(b2), .cin_in(cin2),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2)
  );

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy4, done4, cout4, sum4} !== 35'd0) begin
      errors++;
      $display("FAIL reset4 busy=%b done=%b cout=%b sum=%h expected all 0", busy4, done4, cout4, sum4);
    end
    checks++;
    if ({busy2, done2, cout2, sum2} !== 19'd0) begin
      errors++;
      $display("FAIL reset2 busy=%b done=%b cout=%b sum=%h expected all 0", busy2, done2, cout2, sum2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One NBYTES=4 op: accept at edge T, then sample at the negedge after
  // edges T..T+5. busy expected after T..T+4, done only after T+4.
  // poke=1 re-asserts start with different operands while busy.
  task automatic op4(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic sb, input logic poke,
                     input logic [31:0] exp_sum, input logic exp_cout);
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub4 = sb;
`else
    if (sb) $display("note: sub requested in add-only build (%s)", name);
`endif
    @(posedge clk);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) start4 = 1'b0;
      if (poke && i == 1) begin start4 = 1'b1; a4 = 32'hDEADBEEF; b4 = 32'h0BADF00D; end
      if (poke && i == 3) start4 = 1'b0;
      checks++;
      if (busy4 !== (i <= 4)) begin
        errors++;
        $display("FAIL %s busy[%0d] got=%b expected=%b", name, i, busy4, (i <= 4));
      end
      checks++;
      if (done4 !== (i == 4)) begin
        errors++;
        $display("FAIL %s done[%0d] got=%b expected=%b", name, i, done4, (i == 4));
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (sum4 !== exp_sum || cout4 !== exp_cout) begin
          errors++;
          $display("FAIL %s result[%0d] got=%h/%b expected=%h/%b", name, i, sum4, cout4, exp_sum, exp_cout);
        end
      end
    end
    if (poke) begin
      // start was low at the IDLE edge, so nothing new should run
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || sum4 !== exp_sum || cout4 !== exp_cout) begin
        errors++;
        $display("FAIL %s_ignored busy=%b sum=%h cout=%b expected 0/%h/%b", name, busy4, sum4, cout4, exp_sum, exp_cout);
      end
    end
  endtask

  task automatic test_basic;
    op4("carry_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1);
    op4("cin_add",    32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b1, 32'h2345678A, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_s;
    logic        exp_c;
    a4 = 32'h80000000; b4 = 32'h80000000; cin4 = 1'b0; start4 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub4 = 1'b0;
`endif
    @(posedge clk);
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin a4 = 32'h0000FFFF; b4 = 32'h00000001; cin4 = 1'b1; end
      if (i == 10) start4 = 1'b0;
      checks++;
      if (busy4 !== (i != 5 && i != 11 && i != 12)) begin
        errors++;
        $display("FAIL b2b busy[%0d] got=%b", i, busy4);
      end
      checks++;
      if (done4 !== (i == 4 || i == 10)) begin
        errors++;
        $display("FAIL b2b done[%0d] got=%b", i, done4);
      end
      if (i == 4 || i == 10) begin
        exp_s = (i == 4) ? 32'h00000000 : 32'h00010001;
        exp_c = (i == 4);
        checks++;
        if (sum4 !== exp_s || cout4 !== exp_c) begin
          errors++;
          $display("FAIL b2b result[%0d] got=%h/%b expected=%h/%b", i, sum4, cout4, exp_s, exp_c);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    a4 = 32'h01020304; b4 = 32'h10203040; cin4 = 1'b0; start4 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub4 = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); reset = 1'b1;   // sampled at the edge ending the 2nd RUN cycle
    @(negedge clk);
    checks++;
    if ({busy4, done4, cout4, sum4} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b cout=%b sum=%h expected all 0", busy4, done4, cout4, sum4);
    end
    reset = 1'b0;
    @(negedge clk);
    op4("after_reset", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000002, 1'b0);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    op4("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);
    op4("sub_pos", 32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b1);
    op4("sub_off", 32'h00000007, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'h0000000D, 1'b0);
  endtask
`endif

  task automatic test_random_n2;
    logic [16:0] ref_v;
    for (int n = 0; n < 2000; n++) begin
      a2 = 16'($urandom); b2 = 16'($urandom); cin2 = 1'($urandom);
      if (n == 0) begin a2 = 16'hFFFF; b2 = 16'hFFFF; cin2 = 1'b1; end
      ref_v = {1'b0, a2} + {1'b0, b2} + {16'd0, cin2};
      start2 = 1'b1;
      @(posedge clk);
      for (int i = 0; i <= 3; i++) begin
        @(negedge clk);
        if (i == 0) begin
          start2 = 1'b0;
          a2 = ~a2; b2 = ~b2; cin2 = ~cin2;   // must not affect the running op
        end
        if (i == 1 || i == 2) begin
          checks++;
          if (done2 !== (i == 2)) begin
            errors++;
            $display("FAIL rnd2 op%0d done[%0d] got=%b", n, i, done2);
          end
        end
        if (i == 2) begin
          checks++;
          if ({cout2, sum2} !== ref_v || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL rnd2 op%0d got=%b/%h busy=%b expected=%h", n, cout2, sum2, busy2, ref_v);
          end
        end
        if (i == 3) begin
          checks++;
          if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL rnd2 op%0d busy after done got=%b", n, busy2);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub4 = 1'b0; sub2 = 1'b0;
`endif
    @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_reset_mid_run;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    test_random_n2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
